// File: rtl/d_reg_pkg.sv
// Shared constants and helpers for the d_reg_pipe register pipeline.
package d_reg_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 4;

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_reg_stage.sv
// One pipeline stage: data/valid registers with a bubble-collapsing accept term.
// Optional flush input present when D_REG_PIPE_FLUSH_EN is defined.
module d_reg_stage
    import d_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
`ifdef D_REG_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    input  logic             down_accept,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             accept
);

    // An empty stage takes upstream data even when downstream is stalled.
    assign accept = !valid || down_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end
`ifdef D_REG_PIPE_FLUSH_EN
        else if (flush) begin
            valid <= 1'b0;
        end
`endif
        else if (accept) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/d_reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with occupancy count.
// Defining D_REG_PIPE_FLUSH_EN adds a flush input that empties the pipe.
module d_reg_pipe
    import d_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef D_REG_PIPE_FLUSH_EN
    input  logic                           flush,
`endif
    input  logic [WIDTH-1:0]               D,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               q,
    output logic [WIDTH-1:0]               q_bar,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [occ_width(DEPTH)-1:0]    occupancy
);

    localparam int unsigned OccW = occ_width(DEPTH);
    localparam logic [OccW-1:0] OccOne = 1;

    logic            push;
    logic            pop;
    logic [OccW-1:0] occ_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] up_data;
        logic [WIDTH-1:0] data;
        logic             up_valid;
        logic             down_accept;
        logic             valid;
        logic             accept;

        if (k == 0) begin : g_first
            assign up_data  = D;
            assign up_valid = push;
        end else begin : g_mid
            assign up_data  = g_stage[k-1].data;
            assign up_valid = g_stage[k-1].valid;
        end

        if (k == DEPTH - 1) begin : g_last
            assign down_accept = out_ready;
        end else begin : g_inner
            assign down_accept = g_stage[k+1].accept;
        end

        d_reg_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
`ifdef D_REG_PIPE_FLUSH_EN
            .flush      (flush),
`endif
            .up_data    (up_data),
            .up_valid   (up_valid),
            .down_accept(down_accept),
            .data       (data),
            .valid      (valid),
            .accept     (accept)
        );
    end

    assign in_ready  = g_stage[0].accept;
    assign push      = in_valid && in_ready;
    assign q         = g_stage[DEPTH-1].data;
    assign q_bar     = ~q;
    assign out_valid = g_stage[DEPTH-1].valid;
    assign pop       = out_valid && out_ready;
    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end
`ifdef D_REG_PIPE_FLUSH_EN
        else if (flush) begin
            occ_q <= '0;
        end
`endif
        else if (push && !pop) begin
            occ_q <= occ_q + OccOne;
        end else if (pop && !push) begin
            occ_q <= occ_q - OccOne;
        end
    end

endmodule

// File: doc/d_reg_pipe.md
D_REG_PIPE -- requirements
Module: d_reg_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bit width (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of register stages (>=1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port D, input, WIDTH bits: input data.
REQ-006 The block SHALL have port in_valid, input, 1 bit: D is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the pipe accepts D this cycle.
REQ-008 The block SHALL have port q, output, WIDTH bits: data of the last stage.
REQ-009 The block SHALL have port q_bar, output, WIDTH bits: bitwise inverse of q.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the last stage holds a valid beat.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes q this cycle.
REQ-012 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: count of valid stages.

Function
REQ-013 Each stage k SHALL hold data[k] and valid[k]; stage 0 is the input stage and stage DEPTH-1 drives q and out_valid.
REQ-014 accept[DEPTH-1] SHALL equal !valid[DEPTH-1] || out_ready; for k<DEPTH-1, accept[k] SHALL equal !valid[k] || accept[k+1].
REQ-015 in_ready SHALL equal accept[0], combinationally.
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 On an edge where accept[k] is high, stage k SHALL load the data and valid of its upstream neighbour (stage 0 loads D and in_valid && in_ready).
REQ-018 Bubbles SHALL collapse: an empty stage accepts upstream data even when downstream is stalled.
REQ-019 data[k] SHALL change only when a valid beat is loaded into stage k; otherwise it SHALL hold.
REQ-020 With the pipe empty and out_ready high, a beat presented in cycle n SHALL appear with out_valid in cycle n+DEPTH.
REQ-021 Beats SHALL emerge in acceptance order with no loss or duplication.
REQ-022 occupancy SHALL be a registered count: +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither; it SHALL never exceed DEPTH.
REQ-023 When full with out_ready high, in_ready SHALL be high; the simultaneous push and pop SHALL leave occupancy at DEPTH.
REQ-024 q_bar SHALL equal ~q at all times, including during reset.

Reset
REQ-025 While rst is high at an edge, all valid[k] SHALL clear, all data[k] SHALL clear to 0 and occupancy SHALL clear to 0. Reset SHALL take priority over every transfer.
REQ-026 After reset, out_valid SHALL be 0, q SHALL be 0 and q_bar SHALL be all ones.
REQ-027 A beat in flight when reset is asserted SHALL never emerge.

Configuration
REQ-028 With macro D_REG_PIPE_FLUSH_EN defined, the block SHALL have an input port flush (1 bit). flush high at an edge SHALL clear all valid[k] and occupancy, SHALL hold data[k], and SHALL drop any input offered that cycle.
REQ-029 The priority order SHALL be rst, then flush, then transfers.
REQ-030 Without D_REG_PIPE_FLUSH_EN, the flush port and its logic SHALL be absent.

Structure
REQ-031 Package d_reg_pkg SHALL hold the default WIDTH and DEPTH constants and a function for the occupancy width.
REQ-032 Sub-module d_reg_stage SHALL implement one stage: data and valid registers, the accept term and load enable. d_reg_pipe SHALL instantiate it DEPTH times with a generate loop.

Verification (WIDTH=8, DEPTH=4)
REQ-033 Reset: rst=1 for 2 cycles -> out_valid=0, q=0x00, q_bar=0xFF, occupancy=0, in_ready=1.
REQ-034 Latency: push 0xA5 once at cycle 0 with out_ready=1 -> out_valid=1, q=0xA5, q_bar=0x5A in cycle 4, and out_valid=0 in cycle 5.
REQ-035 Backpressure: out_ready=0 while streaming 0x01..0x06 -> exactly 0x01..0x04 accepted, in_ready=0, occupancy=4. Then raise out_ready -> 0x01..0x04 out in order, then 0x05 and 0x06.
REQ-036 Full push and pop: occupancy=4, in_valid=1 and out_ready=1 for 3 cycles -> 3 beats in and 3 beats out, occupancy stays 4.
REQ-037 Mid-operation reset: occupancy=3, rst pulsed for 1 cycle -> next cycle occupancy=0, q=0x00, and none of the 3 beats ever appears.
REQ-038 Flush (macro defined): occupancy=2, flush=1 with in_valid=1 and D=0x77 -> occupancy=0, out_valid=0, and 0x77 never emerges.
